accel_bcd_formatter: RTL and testbench
======================================

Name: accel_bcd_formatter

Overview:
Consumes the raw signed X/Y samples and the update strobe from the SPI accelerometer controller. Optionally box-car averages 2^AVG_LOG2 samples per axis, then converts each average to sign + 3-digit BCD magnitude using a sequential shift-add-3 (double dabble) engine. Drives the seg7 digit inputs and a per-axis negative flag for a sign LED/segment. Sits between spi_control and the seg7 instances in the top level.

Parameters:
DATA_W, 16, sample width (two's complement)
AVG_LOG2, 2, log2 of samples averaged per displayed value; 0 = no averaging
BIN_W, 10, magnitude bits converted by double dabble (covers 0..999)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
data_update  in  1  sample-ready level/strobe from spi_control; rising edge = new sample
data_x  in  DATA_W  signed X sample
data_y  in  DATA_W  signed Y sample
x_bcd  out  12  X magnitude BCD {hundreds,tens,units}
y_bcd  out  12  Y magnitude BCD
x_neg  out  1  X average < 0
y_neg  out  1  Y average < 0
x_sat  out  1  X magnitude > 999, digits forced to 999
y_sat  out  1  Y magnitude > 999, digits forced to 999
disp_valid  out  1  one-cycle pulse: all outputs just updated
busy  out  1  conversion in progress
overrun  out  1  sticky: sample edge dropped while busy

Behaviour:
- One clock; reset is synchronous and active-high. Reset: all outputs 0, edge-detect register 0, accumulators 0, sample count 0, state IDLE. Reset mid-conversion aborts; no disp_valid.
- Edge detect: upd_q registers data_update; edge = data_update & ~upd_q. A level held high counts once.
- States: IDLE, CONV (BIN_W cycles), back to IDLE.
- IDLE, edge: acc_x += sign-extended data_x, acc_y likewise (width DATA_W+AVG_LOG2, no overflow possible); count++. When the edge is the 2^AVG_LOG2-th: avg = (acc incl. this sample) >>> AVG_LOG2 (arithmetic, floor toward -inf), accumulators and count cleared, go CONV.
- Magnitude: neg = avg<0; mag = neg ? -avg : avg computed at DATA_W+1 bits (-32768 -> 32768). If mag > 999: sat=1, result 0x999, engine still runs but result overridden.
- CONV: X and Y converted in parallel, one shift-add-3 step per cycle, exactly BIN_W cycles; busy=1 throughout.
- Timing (edge sampled in cycle 0): busy=1 cycles 1..BIN_W; x_bcd/y_bcd/x_neg/y_neg/x_sat/y_sat update and disp_valid=1 in cycle BIN_W+1 (cycle 11 at default); state IDLE in cycle BIN_W+1, so an edge in that cycle is accepted.
- Outputs hold between updates; disp_valid high exactly one cycle per conversion.
- Edge while busy: sample dropped, accumulators/count untouched, overrun set; cleared only by reset.
- Zero never reported negative (avg=0 -> neg=0); avg=-1 reports neg=1, 0x001.

Test Plan:
- AVG_LOG2=0, one edge x=123, y=-45 -> cycle 11: x_bcd=0x123 x_neg=0, y_bcd=0x045 y_neg=1, sat=0, disp_valid single pulse.
- AVG_LOG2=0, x=-32768, y=1000 -> x_bcd=0x999 x_neg=1 x_sat=1; y_bcd=0x999 y_neg=0 y_sat=1; x=999 -> 0x999 with x_sat=0.
- AVG_LOG2=2, x=10,11,12,13, y=-1,-1,-1,-2 -> no disp_valid for edges 1-3; after 4th: x_bcd=0x011, y_bcd=0x002 y_neg=1.
- AVG_LOG2=0, second edge at cycle 5 after first -> overrun=1, only one disp_valid, values from first sample; next edge after cycle 11 converts normally, overrun stays 1.
- data_update held high 20 cycles -> one sample counted, one disp_valid.
- reset asserted at cycle 6 of a conversion -> all outputs 0, busy=0, no disp_valid; subsequent edge x=7 -> x_bcd=0x007 at cycle 11.

Source files
------------

// File: rtl/accel_bcd_formatter_if.sv
// ============================================================================
// accel_bcd_formatter_if : sample-in / BCD-out bundle for accel_bcd_formatter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface accel_bcd_formatter_if #(
  parameter int DATA_W = 16
);
  logic              data_update;
  logic [DATA_W-1:0] data_x;
  logic [DATA_W-1:0] data_y;
  logic [11:0]       x_bcd;
  logic [11:0]       y_bcd;
  logic              x_neg;
  logic              y_neg;
  logic              x_sat;
  logic              y_sat;
  logic              disp_valid;
  logic              busy;
  logic              overrun;

  // Upstream sample source / display consumer
  modport master (
    output data_update, data_x, data_y,
    input  x_bcd, y_bcd, x_neg, y_neg, x_sat, y_sat, disp_valid, busy, overrun
  );

  // The formatter itself
  modport slave (
    input  data_update, data_x, data_y,
    output x_bcd, y_bcd, x_neg, y_neg, x_sat, y_sat, disp_valid, busy, overrun
  );
endinterface

`default_nettype wire

// File: rtl/accel_bcd_formatter.sv
// ============================================================================
// accel_bcd_formatter : averages signed X/Y samples, converts to sign + BCD
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_bcd_formatter #(
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 2,
  parameter int BIN_W    = 10
) (
  input  wire logic               clk,
  input  wire logic               reset,
  accel_bcd_formatter_if.slave    bus
);

  localparam int SUM_W  = DATA_W + AVG_LOG2;
  localparam int MAG_W  = DATA_W + 1;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int STEP_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BIN_W - 1);
  localparam logic [MAG_W-1:0]  MAG_MAX   = MAG_W'(999);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_e;

  function automatic logic [11:0] dd_adj(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++)
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    return r;
  endfunction

  // Extra bit so that the most negative sample has a representable magnitude
  function automatic logic [MAG_W-1:0] abs_mag(input logic signed [DATA_W-1:0] a);
    logic signed [MAG_W-1:0] e;
    e = MAG_W'(a);
    return a[DATA_W-1] ? MAG_W'(-e) : MAG_W'(e);
  endfunction

  state_e                    state_q, state_d;
  logic                      upd_q;
  logic signed [SUM_W-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [STEP_W-1:0]         step_q, step_d;
  logic [BIN_W-1:0]          x_bin_q, x_bin_d, y_bin_q, y_bin_d;
  logic [11:0]               x_dd_q, x_dd_d, y_dd_q, y_dd_d;
  logic                      x_negp_q, x_negp_d, y_negp_q, y_negp_d;
  logic                      x_satp_q, x_satp_d, y_satp_q, y_satp_d;
  logic [11:0]               x_bcd_q, x_bcd_d, y_bcd_q, y_bcd_d;
  logic                      x_neg_q, x_neg_d, y_neg_q, y_neg_d;
  logic                      x_sat_q, x_sat_d, y_sat_q, y_sat_d;
  logic                      dv_q, dv_d;
  logic                      ovr_q, ovr_d;

  logic                      w_edge;
  logic signed [SUM_W-1:0]   w_sum_x, w_sum_y;
  logic signed [DATA_W-1:0]  w_avg_x, w_avg_y;
  logic [MAG_W-1:0]          w_mag_x, w_mag_y;
  logic [BIN_W+11:0]         w_x_step, w_y_step;

  assign w_edge   = bus.data_update & ~upd_q;
  assign w_sum_x  = acc_x_q + SUM_W'($signed(bus.data_x));
  assign w_sum_y  = acc_y_q + SUM_W'($signed(bus.data_y));
  assign w_avg_x  = DATA_W'(w_sum_x >>> AVG_LOG2);
  assign w_avg_y  = DATA_W'(w_sum_y >>> AVG_LOG2);
  assign w_mag_x  = abs_mag(w_avg_x);
  assign w_mag_y  = abs_mag(w_avg_y);
  assign w_x_step = {dd_adj(x_dd_q), x_bin_q} << 1;
  assign w_y_step = {dd_adj(y_dd_q), y_bin_q} << 1;

  always_comb begin
    state_d  = state_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    x_bin_d  = x_bin_q;
    y_bin_d  = y_bin_q;
    x_dd_d   = x_dd_q;
    y_dd_d   = y_dd_q;
    x_negp_d = x_negp_q;
    y_negp_d = y_negp_q;
    x_satp_d = x_satp_q;
    y_satp_d = y_satp_q;
    x_bcd_d  = x_bcd_q;
    y_bcd_d  = y_bcd_q;
    x_neg_d  = x_neg_q;
    y_neg_d  = y_neg_q;
    x_sat_d  = x_sat_q;
    y_sat_d  = y_sat_q;
    dv_d     = 1'b0;
    ovr_d    = ovr_q;

    case (state_q)
      S_IDLE: begin
        if (w_edge) begin
          if (cnt_q == CNT_LAST) begin
            acc_x_d  = '0;
            acc_y_d  = '0;
            cnt_d    = '0;
            step_d   = '0;
            x_dd_d   = '0;
            y_dd_d   = '0;
            x_bin_d  = w_mag_x[BIN_W-1:0];
            y_bin_d  = w_mag_y[BIN_W-1:0];
            x_negp_d = w_avg_x[DATA_W-1];
            y_negp_d = w_avg_y[DATA_W-1];
            x_satp_d = (w_mag_x > MAG_MAX);
            y_satp_d = (w_mag_y > MAG_MAX);
            state_d  = S_CONV;
          end else begin
            acc_x_d = w_sum_x;
            acc_y_d = w_sum_y;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end

      S_CONV: begin
        if (w_edge)
          ovr_d = 1'b1;
        {x_dd_d, x_bin_d} = w_x_step;
        {y_dd_d, y_bin_d} = w_y_step;
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_LAST) begin
          x_bcd_d = x_satp_q ? 12'h999 : w_x_step[BIN_W +: 12];
          y_bcd_d = y_satp_q ? 12'h999 : w_y_step[BIN_W +: 12];
          x_neg_d = x_negp_q;
          y_neg_d = y_negp_q;
          x_sat_d = x_satp_q;
          y_sat_d = y_satp_q;
          dv_d    = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      upd_q    <= 1'b0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      x_bin_q  <= '0;
      y_bin_q  <= '0;
      x_dd_q   <= '0;
      y_dd_q   <= '0;
      x_negp_q <= 1'b0;
      y_negp_q <= 1'b0;
      x_satp_q <= 1'b0;
      y_satp_q <= 1'b0;
      x_bcd_q  <= '0;
      y_bcd_q  <= '0;
      x_neg_q  <= 1'b0;
      y_neg_q  <= 1'b0;
      x_sat_q  <= 1'b0;
      y_sat_q  <= 1'b0;
      dv_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      upd_q    <= bus.data_update;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      x_bin_q  <= x_bin_d;
      y_bin_q  <= y_bin_d;
      x_dd_q   <= x_dd_d;
      y_dd_q   <= y_dd_d;
      x_negp_q <= x_negp_d;
      y_negp_q <= y_negp_d;
      x_satp_q <= x_satp_d;
      y_satp_q <= y_satp_d;
      x_bcd_q  <= x_bcd_d;
      y_bcd_q  <= y_bcd_d;
      x_neg_q  <= x_neg_d;
      y_neg_q  <= y_neg_d;
      x_sat_q  <= x_sat_d;
      y_sat_q  <= y_sat_d;
      dv_q     <= dv_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.x_bcd      = x_bcd_q;
  assign bus.y_bcd      = y_bcd_q;
  assign bus.x_neg      = x_neg_q;
  assign bus.y_neg      = y_neg_q;
  assign bus.x_sat      = x_sat_q;
  assign bus.y_sat      = y_sat_q;
  assign bus.disp_valid = dv_q;
  assign bus.busy       = (state_q == S_CONV);
  assign bus.overrun    = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_accel_bcd_formatter.sv
// ============================================================================
// tb_accel_bcd_formatter : directed checks on a non-averaging and a 4-sample
// averaging instance sharing one clock and reset
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accel_bcd_formatter;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   dv0;
  int   dv2;

  accel_bcd_formatter_if #(.DATA_W(16)) if0 ();
  accel_bcd_formatter_if #(.DATA_W(16)) if2 ();

  accel_bcd_formatter #(.DATA_W(16), .AVG_LOG2(0), .BIN_W(10)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  accel_bcd_formatter #(.DATA_W(16), .AVG_LOG2(2), .BIN_W(10)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (if0.disp_valid) dv0++;
    if (if2.disp_valid) dv2++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Raise data_update for one cycle; returns at the negedge of cycle 1
  task automatic send(input bit which, input int x, input int y);
    @(negedge clk);
    if (which) begin
      if2.data_x = 16'(x); if2.data_y = 16'(y); if2.data_update = 1'b1;
    end else begin
      if0.data_x = 16'(x); if0.data_y = 16'(y); if0.data_update = 1'b1;
    end
    @(negedge clk);
    if (which) if2.data_update = 1'b0;
    else       if0.data_update = 1'b0;
  endtask

  task automatic wait_dv(input bit which, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = which ? if2.disp_valid : if0.disp_valid;
    end
    check_eq({tag, "_done"}, 32'(seen), 32'd1);
  endtask

  task automatic check_xy0(input string tag, input logic [11:0] xb, input logic xn, input logic xs,
                           input logic [11:0] yb, input logic yn, input logic ys);
    check_eq({tag, "_x_bcd"}, 32'(if0.x_bcd), 32'(xb));
    check_eq({tag, "_x_flags"}, {30'd0, if0.x_neg, if0.x_sat}, {30'd0, xn, xs});
    check_eq({tag, "_y_bcd"}, 32'(if0.y_bcd), 32'(yb));
    check_eq({tag, "_y_flags"}, {30'd0, if0.y_neg, if0.y_sat}, {30'd0, yn, ys});
  endtask

  initial begin
    int  base;
    bit  early;
    n_vec = 0; n_err = 0; dv0 = 0; dv2 = 0;
    reset = 1'b1;
    if0.data_update = 1'b0; if0.data_x = '0; if0.data_y = '0;
    if2.data_update = 1'b0; if2.data_x = '0; if2.data_y = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check_eq("rst_outputs0",
             {5'd0, if0.x_bcd, if0.y_bcd, if0.x_neg, if0.y_neg, if0.x_sat},
             32'd0);
    check_eq("rst_status0", {28'd0, if0.y_sat, if0.disp_valid, if0.busy, if0.overrun}, 32'd0);
    check_eq("rst_status2", {28'd0, if2.x_neg, if2.disp_valid, if2.busy, if2.overrun}, 32'd0);

    // Exact latency: busy from cycle 1, results and pulse in cycle 11
    send(0, 123, -45);
    check_eq("t1_busy_c1", 32'(if0.busy), 32'd1);
    early = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (if0.disp_valid || !if0.busy) early = 1'b1;
    end
    check_eq("t1_no_early", 32'(early), 32'd0);
    @(negedge clk);
    check_eq("t1_dv_c11", 32'(if0.disp_valid), 32'd1);
    check_eq("t1_busy_c11", 32'(if0.busy), 32'd0);
    check_xy0("t1", 12'h123, 1'b0, 1'b0, 12'h045, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("t1_dv_c12", 32'(if0.disp_valid), 32'd0);

    send(0, -32768, 1000);
    wait_dv(0, "t2");
    check_xy0("t2", 12'h999, 1'b1, 1'b1, 12'h999, 1'b0, 1'b1);

    send(0, 999, 0);
    wait_dv(0, "t3");
    check_xy0("t3", 12'h999, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);

    send(0, -1, 500);
    wait_dv(0, "t4");
    check_xy0("t4", 12'h001, 1'b1, 1'b0, 12'h500, 1'b0, 1'b0);

    // Averaging: x mean 11.5 -> 11, y sum -5 >>> 2 -> -2
    base = dv2;
    send(1, 10, -1);  repeat (2) @(negedge clk);
    send(1, 11, -1);  repeat (2) @(negedge clk);
    send(1, 12, -1);  repeat (13) @(negedge clk);
    check_eq("avg_no_dv_edges1to3", 32'(dv2 - base), 32'd0);
    check_eq("avg_not_busy", 32'(if2.busy), 32'd0);
    send(1, 13, -2);
    wait_dv(1, "avg");
    check_eq("avg_x_bcd", 32'(if2.x_bcd), 32'h011);
    check_eq("avg_y_bcd", 32'(if2.y_bcd), 32'h002);
    check_eq("avg_flags", {28'd0, if2.x_neg, if2.y_neg, if2.x_sat, if2.y_sat}, 32'b0100);

    // Overrun: second edge during conversion is dropped
    base = dv0;
    send(0, 321, 5);
    repeat (3) @(negedge clk);
    if0.data_x = 16'd777; if0.data_y = 16'd777; if0.data_update = 1'b1;
    @(negedge clk);
    if0.data_update = 1'b0;
    wait_dv(0, "ovr");
    check_xy0("ovr", 12'h321, 1'b0, 1'b0, 12'h005, 1'b0, 1'b0);
    check_eq("ovr_flag", 32'(if0.overrun), 32'd1);
    repeat (15) @(negedge clk);
    check_eq("ovr_one_dv", 32'(dv0 - base), 32'd1);
    send(0, 222, -9);
    wait_dv(0, "ovr_next");
    check_xy0("ovr_next", 12'h222, 1'b0, 1'b0, 12'h009, 1'b1, 1'b0);
    check_eq("ovr_sticky", 32'(if0.overrun), 32'd1);

    // Level held high counts once
    repeat (2) @(negedge clk);
    base = dv0;
    if0.data_x = 16'd55; if0.data_y = 16'd66; if0.data_update = 1'b1;
    repeat (20) @(negedge clk);
    if0.data_update = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("hold_one_dv", 32'(dv0 - base), 32'd1);
    check_eq("hold_x_bcd", 32'(if0.x_bcd), 32'h055);

    // Reset mid-conversion aborts without a pulse
    send(0, 888, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base = dv0;
    check_eq("midrst_bcd", {8'd0, if0.x_bcd, if0.y_bcd}, 32'd0);
    check_eq("midrst_status",
             {25'd0, if0.x_neg, if0.y_neg, if0.x_sat, if0.y_sat, if0.disp_valid, if0.busy, if0.overrun},
             32'd0);
    repeat (15) @(negedge clk);
    check_eq("midrst_no_dv", 32'(dv0 - base), 32'd0);
    send(0, 7, 0);
    wait_dv(0, "post_rst");
    check_eq("post_rst_x_bcd", 32'(if0.x_bcd), 32'h007);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
